decode_ctrl: RTL and testbench
==============================

# decode_ctrl

Decode and control stage sitting directly downstream of the instruction fetch unit. It launches a program by pulsing the fetch unit's start interface. It latches each 9-bit instruction into an instruction register for the execute stage and resolves branches back to fetch in the same cycle. It stops issuing on HALT and counts retired instructions.

## Interface
Parameters:
- `CNT_W`, 16: width of the retired-instruction counter.

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `go`  in  1  program launch request, level-sampled.
- `program_base`  in  7  program entry address, sampled when `go` is accepted.
- `instruction`  in  9  instruction currently presented by fetch.
- `zero_flag`  in  1  ALU zero flag, valid in the current cycle.
- `start`  out  1  one-cycle load pulse to fetch.
- `start_address`  out  7  PC load value to fetch.
- `branch`  out  1  current instruction is a branch.
- `taken`  out  1  branch condition met.
- `offset`  out  5  signed PC offset to fetch (two's complement, −16..+15).
- `opcode`  out  3  IR[8:6], to execute.
- `operand`  out  6  IR[5:0], to execute.
- `valid`  out  1  IR holds a live instruction this cycle.
- `done`  out  1  program halted.
- `retired`  out  CNT_W  count of retired non-HALT instructions.

## Operation
- Instruction format: [8:6] opcode, [5:0] operand.
  - Opcode 3'b110 is BR: [5] is the condition polarity, [4:0] is the offset.
  - Opcode 3'b111 is HALT; the operand is ignored.
- FSM states:
  - IDLE: `go`=1 → LAUNCH.
  - LAUNCH: → RUN, unconditionally.
  - RUN: an accepted HALT → DONE.
  - DONE: `go`=1 → LAUNCH.
  - `go` is ignored in LAUNCH and RUN.
- On accepting `go` (IDLE or DONE), latch `program_base` into `start_address`. `start_address` holds that value until the next launch.
- LAUNCH:
  - `start`=1 for exactly this one cycle.
  - `retired` is cleared and `done`=0.
- RUN, each edge:
  - IR ← `instruction`.
  - `valid` ← 1 unless the instruction is HALT.
  - `retired` increments for every non-HALT instruction, including branches, and saturates at all-ones.
- HALT accepted in RUN:
  - `valid` ← 0, `done` ← 1, state → DONE.
  - IR keeps the HALT word.
- `branch`, `taken` and `offset` are combinational from `instruction` and `zero_flag`, gated by state==RUN:
  - `branch` = (opcode==110).
  - `taken` = `branch` & (`zero_flag` == instruction[5]).
  - `offset` = instruction[4:0].
  - Outside RUN, or for non-branch opcodes, all three are 0.
- Offset arithmetic and PC wrap-around are owned by fetch. This block passes the 5 bits unmodified.
- In IDLE, LAUNCH and DONE, `valid`=0 and the IR holds its last value.

## Timing
- Reset values:
  - state=IDLE.
  - `start`=0, `start_address`=0, `opcode`=0, `operand`=0, `valid`=0, `done`=0, `retired`=0.
  - Combinational `branch`/`taken`/`offset` are 0 because state≠RUN.
- Launch latency:
  - `go` high at edge N (state IDLE) → `start`=1 during cycle N..N+1.
  - Fetch loads PC at edge N+1.
  - First instruction is presented in cycle N+1..N+2 and latched at edge N+2, giving `valid`=1 after N+2.
- Branch: `branch`/`taken` are asserted in the same cycle the branch word is on `instruction`. Fetch applies it at the next edge.
- `retired` and IR update on the same edge; `retired` reflects instructions up to and including the current IR.
- Reset has priority over everything:
  - Asserted mid-RUN, the next edge returns all outputs to reset values.
  - A pending `start` pulse is cancelled.
- `go` held high continuously produces one launch per entry into IDLE/DONE, not repeated pulses.

## Structure
- Shared package `isa_pkg`:
  - Opcode constants `OP_BR`=3'b110 and `OP_HALT`=3'b111.
  - Field widths: instruction 9, PC 7, offset 5.
  - `ctrl_state_t` enum {IDLE, LAUNCH, RUN, DONE}.
- One natural sub-module: `retire_counter` (clear, enable, saturating, width `CNT_W`). The FSM and IR stay in `decode_ctrl`.

## Test plan
- Reset, then `go`=1 with `program_base`=34 → `start`=1 for exactly one cycle and `start_address`=34; `valid` rises two edges after `go` is accepted; `retired`=0 before the first instruction.
- In RUN, `instruction`=9'b110_1_11011 with `zero_flag`=1 → `branch`=1, `taken`=1, `offset`=5'b11011 (−5) the same cycle; the next edge gives `opcode`=6, `valid`=1, `retired` incremented.
- Same branch word with `zero_flag`=0 → `branch`=1, `taken`=0; a non-branch word (9'b010_000101) → `branch`=`taken`=0.
- Three ordinary instructions then 9'b111_000000 → `retired`=3, `valid`=0, `done`=1; `go` pulse → `retired` cleared, `start` pulses with the newly sampled `program_base`.
- `reset` asserted mid-RUN, coincident with a branch → next cycle all outputs are at reset values and `branch`=0; `go` during RUN is ignored (no `start` pulse).
- Force `retired` near saturation (`CNT_W`=4, 16 instructions) → holds at 15, no wrap.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA constants, state encoding and instruction layout
// for the decode/control stage.
package isa_pkg;

  localparam int INSTR_W = 9;
  localparam int PC_W    = 7;
  localparam int OFF_W   = 5;

  localparam logic [2:0] OP_BR   = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN,
    DONE
  } ctrl_state_t;

  typedef struct packed {
    logic [2:0] opcode;
    logic [5:0] operand;
  } instr_t;

endpackage

// File: rtl/decode_ctrl_if.sv
// Fetch/execute facing signal bundle of decode_ctrl.
// slave is the decode stage view, master the surrounding system.
interface decode_ctrl_if #(
  parameter int CNT_W = 16
) ();

  logic                       go;
  logic [isa_pkg::PC_W-1:0]   program_base;
  logic [isa_pkg::INSTR_W-1:0] instruction;
  logic                       zero_flag;
  logic                       start;
  logic [isa_pkg::PC_W-1:0]   start_address;
  logic                       branch;
  logic                       taken;
  logic [isa_pkg::OFF_W-1:0]  offset;
  logic [2:0]                 opcode;
  logic [5:0]                 operand;
  logic                       valid;
  logic                       done;
  logic [CNT_W-1:0]           retired;

  modport slave (
    input  go, program_base, instruction, zero_flag,
    output start, start_address, branch, taken, offset,
    output opcode, operand, valid, done, retired
  );

  modport master (
    output go, program_base, instruction, zero_flag,
    input  start, start_address, branch, taken, offset,
    input  opcode, operand, valid, done, retired
  );

endinterface

// File: rtl/decode_ctrl_retire_counter.sv
// Saturating retired-instruction counter with
// synchronous clear and count enable.
module retire_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/decode_ctrl.sv
// Decode/control stage: launches fetch, latches the IR,
// resolves branches combinationally and counts retirements.
module decode_ctrl
  import isa_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic          clock,
  input logic          reset,
  decode_ctrl_if.slave bus
);

  ctrl_state_t     state, state_n;
  instr_t          ir, cur;
  logic [PC_W-1:0] base_q;
  logic            valid_q;
  logic            accept;
  logic            in_run;
  logic            is_halt;
  logic            is_br;

  assign cur     = instr_t'(bus.instruction);
  assign in_run  = (state == RUN);
  assign is_halt = (cur.opcode == OP_HALT);
  assign is_br   = in_run && (cur.opcode == OP_BR);

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (bus.go) begin
          state_n = LAUNCH;
          accept  = 1'b1;
        end
      end
      LAUNCH:  state_n = RUN;
      RUN: begin
        if (is_halt) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      ir      <= '0;
      base_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_n;
      valid_q <= in_run && !is_halt;
      if (accept) base_q <= bus.program_base;
      if (in_run) ir     <= cur;
    end
  end

  // Clearing at acceptance makes retired read 0 throughout LAUNCH.
  retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire (
    .clock (clock),
    .reset (reset),
    .clear (accept),
    .en    (in_run && !is_halt),
    .count (bus.retired)
  );

  assign bus.start         = (state == LAUNCH);
  assign bus.done          = (state == DONE);
  assign bus.start_address = base_q;
  assign bus.opcode        = ir.opcode;
  assign bus.operand       = ir.operand;
  assign bus.valid         = valid_q;
  assign bus.branch        = is_br;
  assign bus.taken         = is_br
                           && (bus.zero_flag == cur.operand[5]);
  assign bus.offset        = is_br ? cur.operand[4:0] : '0;

endmodule

// File: tb/tb_decode_ctrl.sv
// Directed self-checking bench for decode_ctrl.
// Small counter width so saturation is reachable quickly.
module tb_decode_ctrl;

  localparam int CW = 4;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  decode_ctrl_if #(.CNT_W(CW)) bus ();

  decode_ctrl #(
    .CNT_W (CW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_start"}, 32'(bus.start), 0);
    check({tag, "_saddr"}, 32'(bus.start_address), 0);
    check({tag, "_opcode"}, 32'(bus.opcode), 0);
    check({tag, "_operand"}, 32'(bus.operand), 0);
    check({tag, "_valid"}, 32'(bus.valid), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_retired"}, 32'(bus.retired), 0);
    check({tag, "_branch"}, 32'(bus.branch), 0);
    check({tag, "_taken"}, 32'(bus.taken), 0);
    check({tag, "_offset"}, 32'(bus.offset), 0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.go = 1'b0;
    bus.program_base = '0;
    bus.instruction = '0;
    bus.zero_flag = 1'b0;
    tick();
    tick();
    check_reset_state("rst");

    // Launch at base 34, go held high throughout RUN
    reset = 1'b0;
    bus.go = 1'b1;
    bus.program_base = 7'd34;
    tick();
    check("l1_start", 32'(bus.start), 1);
    check("l1_saddr", 32'(bus.start_address), 34);
    check("l1_retired", 32'(bus.retired), 0);
    check("l1_valid", 32'(bus.valid), 0);
    tick();
    check("l1_start_off", 32'(bus.start), 0);
    check("l1_valid_run0", 32'(bus.valid), 0);

    bus.instruction = 9'b110_1_11011;
    bus.zero_flag = 1'b1;
    #1;
    check("br_branch", 32'(bus.branch), 1);
    check("br_taken", 32'(bus.taken), 1);
    check("br_offset", 32'(bus.offset), 32'h1b);
    tick();
    check("br_opcode", 32'(bus.opcode), 6);
    check("br_operand", 32'(bus.operand), 32'h3b);
    check("br_valid", 32'(bus.valid), 1);
    check("br_retired", 32'(bus.retired), 1);
    check("go_run_ign", 32'(bus.start), 0);

    bus.zero_flag = 1'b0;
    #1;
    check("nt_branch", 32'(bus.branch), 1);
    check("nt_taken", 32'(bus.taken), 0);
    tick();
    check("nt_retired", 32'(bus.retired), 2);

    bus.instruction = 9'b010_000101;
    #1;
    check("nb_branch", 32'(bus.branch), 0);
    check("nb_taken", 32'(bus.taken), 0);
    check("nb_offset", 32'(bus.offset), 0);
    tick();
    check("nb_opcode", 32'(bus.opcode), 2);
    check("nb_operand", 32'(bus.operand), 5);

    bus.instruction = 9'b111_000000;
    #1;
    check("h1_branch", 32'(bus.branch), 0);
    tick();
    check("h1_valid", 32'(bus.valid), 0);
    check("h1_done", 32'(bus.done), 1);
    check("h1_retired", 32'(bus.retired), 3);
    check("h1_opcode", 32'(bus.opcode), 7);

    // Relaunch from DONE at base 90 (go still high)
    bus.program_base = 7'd90;
    tick();
    check("l2_start", 32'(bus.start), 1);
    check("l2_saddr", 32'(bus.start_address), 90);
    check("l2_retired", 32'(bus.retired), 0);
    check("l2_done", 32'(bus.done), 0);
    tick();
    check("l2_start_off", 32'(bus.start), 0);
    bus.program_base = 7'd11;
    bus.instruction = 9'b001_000001;
    tick();
    bus.instruction = 9'b011_101010;
    tick();
    bus.instruction = 9'b000_111111;
    tick();
    check("r2_valid", 32'(bus.valid), 1);
    check("r2_operand", 32'(bus.operand), 32'h3f);
    check("r2_saddr_held", 32'(bus.start_address), 90);
    bus.instruction = 9'b111_010101;
    tick();
    check("h2_retired", 32'(bus.retired), 3);
    check("h2_valid", 32'(bus.valid), 0);
    check("h2_done", 32'(bus.done), 1);
    check("h2_ir_halt", 32'({bus.opcode, bus.operand}), 32'h1d5);

    // Third launch, then reset coincident with a branch
    tick();
    check("l3_start", 32'(bus.start), 1);
    check("l3_saddr", 32'(bus.start_address), 11);
    bus.go = 1'b0;
    tick();
    bus.instruction = 9'b110_0_00111;
    bus.zero_flag = 1'b0;
    reset = 1'b1;
    #1;
    check("rb_taken_pre", 32'(bus.taken), 1);
    tick();
    check_reset_state("midrst");

    // Saturation: 16 instructions into a 4-bit counter
    reset = 1'b0;
    bus.go = 1'b1;
    bus.program_base = 7'd5;
    tick();
    check("l4_start", 32'(bus.start), 1);
    tick();
    bus.instruction = 9'b010_000101;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("sat_nostart", 32'(bus.start), 0);
      if (i == 14) check("sat_15", 32'(bus.retired), 15);
    end
    check("sat_hold", 32'(bus.retired), 15);
    check("sat_valid", 32'(bus.valid), 1);
    check("sat_done", 32'(bus.done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
